// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - OTTER data-memory initiator: one request at a time, funct3 decode,
// byte-enabled memory port held stable through the read latency, valid/ready response.
module load_store_unit #(
   parameter int BUS_WIDTH    = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [BUS_WIDTH-1:0] req_addr,
   input  logic [BUS_WIDTH-1:0] req_wdata,
   input  logic [2:0]           req_funct3,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [BUS_WIDTH-1:0] rsp_rdata,
   output logic [1:0]           rsp_fault,
   output logic                 mem_we,
   output logic [BUS_WIDTH-1:0] mem_addr,
   output logic [BUS_WIDTH-1:0] mem_data,
   output logic [1:0]           mem_size,
   output logic                 mem_sign,
   input  logic [BUS_WIDTH-1:0] mem_out,
   input  logic                 mem_error
);

   localparam int CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
   localparam logic [CW-1:0] LAT     = CW'(READ_LATENCY);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [1:0] FAULT_OK      = 2'b00;
   localparam logic [1:0] FAULT_MEM     = 2'b01;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state, state_next;

   logic                 we_q;
   logic [BUS_WIDTH-1:0] addr_q;
   logic [BUS_WIDTH-1:0] wdata_q;
   logic [2:0]           funct3_q;
   logic [CW-1:0]        wait_cnt;
   logic [BUS_WIDTH-1:0] rdata_q;
   logic [1:0]           fault_q;
   logic                 illegal;

   // Reserved size 11, unsigned word load (110/111) and any unsigned store have no meaning.
   assign illegal = (funct3_q[1:0] == 2'b11) || (funct3_q == 3'b110) ||
                    (we_q && funct3_q[2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (req_valid) state_next = S_DECODE;
         S_DECODE: state_next = illegal ? S_RESP : S_ISSUE;
         S_ISSUE:  state_next = (mem_error || we_q) ? S_RESP : S_WAIT;
         S_WAIT:   if (wait_cnt == CNT_ONE) state_next = S_RESP;
         S_RESP:   if (rsp_ready) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // A faulting access never writes: the strobe is gated by the memory's own error flag.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      case (state)
         S_IDLE:  req_ready = 1'b1;
         S_ISSUE: mem_we    = we_q && !mem_error;
         S_RESP:  rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= 3'b000;
         wait_cnt <= '0;
         rdata_q  <= '0;
         fault_q  <= FAULT_OK;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  funct3_q <= req_funct3;
               end
            end
            S_DECODE: begin
               if (illegal) begin
                  fault_q <= FAULT_ILLEGAL;
                  rdata_q <= '0;
               end
            end
            S_ISSUE: begin
               if (mem_error) begin
                  fault_q <= FAULT_MEM;
                  rdata_q <= '0;
               end else if (we_q) begin
                  fault_q <= FAULT_OK;
                  rdata_q <= '0;
               end else begin
                  wait_cnt <= LAT;
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - CNT_ONE;
               if (wait_cnt == CNT_ONE) begin
                  rdata_q <= mem_out;
                  fault_q <= FAULT_OK;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr  = addr_q;
   assign mem_data  = wdata_q;
   assign mem_size  = funct3_q[1:0];
   assign mem_sign  = funct3_q[2];
   assign rsp_rdata = rdata_q;
   assign rsp_fault = fault_q;

endmodule
